// File: rtl/bin_to_onehot_ctrl.sv
// rtl/bin_to_onehot_ctrl.sv - registered binary-to-one-hot decoder with direct and scan modes
//
// Purpose:
//   Decodes a binary code into one of N_OUT one-hot lines. Code 0 selects
//   no line, and code k selects line k (bit k-1). Direct mode registers the
//   decode of each accepted code. Scan mode steps through lines 1..N_OUT on
//   its own, holding each line for i_div+1 cycles.
//
// Ports:
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_mode    0 = direct, 1 = scan; becomes the state on the next edge
//   i_valid   code present on i_code (direct mode)
//   i_code    binary code, 0 = no line
//   o_ready   code accepted when i_valid && o_ready
//   i_div     scan dwell minus one, in cycles per line
//   i_hold    freeze scan position and dwell counter
//   o_onehot  registered one-hot lines, bit k-1 = code k
//   o_idx     registered binary index of the active line (0 = none)
//   o_valid   one-cycle pulse when o_onehot/o_idx were updated
//   o_err     one-cycle pulse with o_valid when the accepted code > N_OUT
module bin_to_onehot_ctrl #(
  parameter int W_IN  = 3,
  parameter int N_OUT = 7,
  parameter int DIV_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mode,
  input  logic               i_valid,
  input  logic [W_IN-1:0]    i_code,
  output logic               o_ready,
  input  logic [DIV_W-1:0]   i_div,
  input  logic               i_hold,
  output logic [N_OUT-1:0]   o_onehot,
  output logic [W_IN-1:0]    o_idx,
  output logic               o_valid,
  output logic               o_err
);

  typedef enum logic {
    S_DIRECT = 1'b0,
    S_SCAN   = 1'b1
  } state_t;

  localparam logic [W_IN-1:0] FIRST_CODE = W_IN'(1);
  localparam logic [W_IN-1:0] LAST_CODE  = W_IN'(N_OUT);

  // Out-of-range codes fall through with no bit set.
  function automatic logic [N_OUT-1:0] decode(input logic [W_IN-1:0] code);
    logic [N_OUT-1:0] oh;
    oh = '0;
    for (int k = 0; k < N_OUT; k++) begin
      oh[k] = (code == W_IN'(k + 1));
    end
    return oh;
  endfunction

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [N_OUT-1:0]   onehot_q, onehot_d;
  logic [W_IN-1:0]    idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [W_IN-1:0]    scan_next;

  assign o_ready  = !i_rst && (state_q == S_DIRECT);
  assign o_onehot = onehot_q;
  assign o_idx    = idx_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;

  assign scan_next = (idx_q == LAST_CODE) ? FIRST_CODE : idx_q + FIRST_CODE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_DIRECT;
      cnt_q    <= '0;
      div_q    <= '0;
      onehot_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = i_mode ? S_SCAN : S_DIRECT;
    cnt_d    = cnt_q;
    div_d    = div_q;
    onehot_d = onehot_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    if (state_d != state_q) begin
      // A mode change takes priority over a pending handshake or terminal count.
      cnt_d = '0;
      div_d = i_div;
      if (state_d == S_SCAN) begin
        idx_d    = FIRST_CODE;
        onehot_d = decode(FIRST_CODE);
        valid_d  = 1'b1;
      end else begin
        idx_d    = '0;
        onehot_d = '0;
      end
    end else if (state_q == S_DIRECT) begin
      if (i_valid && o_ready) begin
        valid_d  = 1'b1;
        onehot_d = decode(i_code);
        if (i_code > LAST_CODE) begin
          idx_d = '0;
          err_d = 1'b1;
        end else begin
          idx_d = i_code;
        end
      end
    end else if (!i_hold) begin
      if (cnt_q == div_q) begin
        // Dwell complete: step, and pick up any new rate for the next dwell.
        cnt_d    = '0;
        div_d    = i_div;
        idx_d    = scan_next;
        onehot_d = decode(scan_next);
        valid_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bin_to_onehot_ctrl.sv
// tb/tb_bin_to_onehot_ctrl.sv - self-checking bench for bin_to_onehot_ctrl
module tb_bin_to_onehot_ctrl;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        valid;
  logic [2:0]  code;
  logic [15:0] div;
  logic        hold;

  logic        ready_a, ready_b;
  logic [6:0]  onehot_a;
  logic [4:0]  onehot_b;
  logic [2:0]  idx_a, idx_b;
  logic        ov_a, ov_b;
  logic        err_a, err_b;

  int errors = 0;
  int checks = 0;
  bit armed  = 0;

  bin_to_onehot_ctrl #(.W_IN(3), .N_OUT(7), .DIV_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_valid(valid), .i_code(code),
    .o_ready(ready_a), .i_div(div), .i_hold(hold), .o_onehot(onehot_a),
    .o_idx(idx_a), .o_valid(ov_a), .o_err(err_a)
  );

  bin_to_onehot_ctrl #(.W_IN(3), .N_OUT(5), .DIV_W(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_valid(valid), .i_code(code),
    .o_ready(ready_b), .i_div(div), .i_hold(hold), .o_onehot(onehot_b),
    .o_idx(idx_b), .o_valid(ov_b), .o_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, scan position plus cycles left in the dwell.
  int nout[2]  = '{7, 5};
  int m_scan[2] = '{0, 0};
  int m_left[2] = '{0, 0};
  int m_idx[2]  = '{0, 0};
  int m_v[2]    = '{0, 0};
  int m_e[2]    = '{0, 0};

  function automatic int exp_oh(input int idx);
    return (idx == 0) ? 0 : (1 << (idx - 1));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_scan[i] = 0; m_left[i] = 0; m_idx[i] = 0; m_v[i] = 0; m_e[i] = 0;
      end else begin
        m_v[i] = 0;
        m_e[i] = 0;
        if (int'(mode) != m_scan[i]) begin
          m_scan[i] = int'(mode);
          m_left[i] = int'(div) + 1;
          m_idx[i]  = mode ? 1 : 0;
          m_v[i]    = mode ? 1 : 0;
        end else if (m_scan[i] == 0) begin
          if (valid) begin
            m_v[i] = 1;
            if (int'(code) > nout[i]) begin
              m_idx[i] = 0;
              m_e[i]   = 1;
            end else begin
              m_idx[i] = int'(code);
            end
          end
        end else if (!hold) begin
          if (m_left[i] == 1) begin
            m_idx[i]  = m_idx[i] % nout[i] + 1;
            m_v[i]    = 1;
            m_left[i] = int'(div) + 1;
          end else begin
            m_left[i] = m_left[i] - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("a_onehot", 32'(onehot_a), exp_oh(m_idx[0]));
      chk("a_idx",    32'(idx_a),    m_idx[0]);
      chk("a_valid",  32'(ov_a),     m_v[0]);
      chk("a_err",    32'(err_a),    m_e[0]);
      chk("a_ready",  32'(ready_a),  (!rst && m_scan[0] == 0) ? 1 : 0);
      chk("a_onebit", $countones(onehot_a) <= 1 ? 1 : 0, 1);
      chk("b_onehot", 32'(onehot_b), exp_oh(m_idx[1]));
      chk("b_idx",    32'(idx_b),    m_idx[1]);
      chk("b_valid",  32'(ov_b),     m_v[1]);
      chk("b_err",    32'(err_b),    m_e[1]);
      chk("b_ready",  32'(ready_b),  (!rst && m_scan[1] == 0) ? 1 : 0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int nxt7(input int p);
    return p % 7 + 1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tbl[8] = '{0, 1, 2, 4, 8, 16, 32, 64};
    int saved;
    int p;
    bit seen;

    rst = 1; mode = 0; valid = 0; code = 0; div = 0; hold = 0;
    armed = 1;
    step();
    chk("rst_onehot", 32'(onehot_a), 0);
    chk("rst_idx",    32'(idx_a),    0);
    chk("rst_valid",  32'(ov_a),     0);
    chk("rst_err",    32'(err_a),    0);
    chk("rst_ready",  32'(ready_a),  0);

    rst = 0;
    step();
    chk("post_rst_ready", 32'(ready_a), 1);

    // Direct sweep, back-to-back codes
    for (int c = 0; c < 8; c++) begin
      code = 3'(c); valid = 1;
      step();
      chk("sweep_onehot", 32'(onehot_a), tbl[c]);
      chk("sweep_idx",    32'(idx_a),    c);
      chk("sweep_valid",  32'(ov_a),     1);
      chk("sweep_err",    32'(err_a),    0);
    end
    valid = 0;
    step();
    chk("idle_valid",  32'(ov_a),     0);
    chk("idle_onehot", 32'(onehot_a), 64);

    // Out-of-range on the N_OUT=5 instance
    code = 3'd6; valid = 1;
    step();
    chk("oor_err",    32'(err_b),    1);
    chk("oor_onehot", 32'(onehot_b), 0);
    chk("oor_valid",  32'(ov_b),     1);
    code = 3'd5;
    step();
    chk("inr_onehot", 32'(onehot_b), 16);
    chk("inr_err",    32'(err_b),    0);
    valid = 0;
    step();
    chk("oor_pulse_end", 32'(err_b), 0);

    // Scan at i_div = 2, code offered during scan must be ignored
    div = 2; mode = 1;
    for (int c = 0; c < 23; c++) begin
      step();
      chk("scan_idx",   32'(idx_a), (c / 3) % 7 + 1);
      chk("scan_valid", 32'(ov_a),  (c % 3 == 0) ? 1 : 0);
      if (c == 0) begin
        valid = 1; code = 3'd3;
      end
      if (c > 0) chk("scan_ready", 32'(ready_a), 0);
    end

    // Hold for 5 cycles
    saved = int'(idx_a);
    hold = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_idx",   32'(idx_a), saved);
      chk("hold_valid", 32'(ov_a),  0);
    end
    hold = 0;

    // Rate change mid-dwell: old dwell completes, then one line per cycle
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (ov_a) seen = 1;
    end
    chk("wait_pulse", 32'(seen), 1);
    p = int'(idx_a);
    step();
    div = 0;
    step();
    chk("rate_old_dwell", 32'(idx_a), p);
    step();
    chk("rate_step1", 32'(idx_a), nxt7(p));
    step();
    chk("rate_step2", 32'(idx_a), nxt7(nxt7(p)));

    // Leave scan with code 3 still offered
    chk("gate_ready", 32'(ready_a), 0);
    mode = 0;
    step();
    chk("sw_onehot", 32'(onehot_a), 0);
    chk("sw_idx",    32'(idx_a),    0);
    chk("sw_valid",  32'(ov_a),     0);
    chk("sw_ready",  32'(ready_a),  1);
    step();
    chk("acc_onehot", 32'(onehot_a), 4);
    chk("acc_valid",  32'(ov_a),     1);
    valid = 0;

    // Reset during scan at o_idx = 4
    div = 0; mode = 1;
    for (int c = 0; c < 4; c++) step();
    chk("pre_rst_idx", 32'(idx_a), 4);
    rst = 1;
    step();
    chk("mrst_onehot", 32'(onehot_a), 0);
    chk("mrst_idx",    32'(idx_a),    0);
    chk("mrst_valid",  32'(ov_a),     0);
    chk("mrst_ready",  32'(ready_a),  0);
    rst = 0;
    step();
    chk("restart_idx",   32'(idx_a), 1);
    chk("restart_valid", 32'(ov_a),  1);

    mode = 0;
    step();
    step();
    armed = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
